// File: rtl/invaders_pkg.sv
// Shared types/constants for the Invaders HPS download controller.
// Holds the loader FSM state enum and the ioctl_index target codes.
package invaders_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    HOLD,
    RUN
  } dl_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/invaders_dl_buf.sv
// One-entry holding buffer between the HPS byte stream and ROM memory.
// Ports: in_* push side (in_ready = empty or draining), out_* = dn_wr side.
module invaders_dl_buf (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_addr,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_addr,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  // A push may land in the same cycle the held entry is accepted.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_addr  <= in_addr;
      out_data  <= in_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/invaders_dl_ctrl.sv
// HPS ioctl download controller: ROM byte stream, mod select, DIP bytes,
// core reset sequencing and download error flag.
// Ports: clk_sys/reset (sync, active-high); ioctl_* HPS side with
// ioctl_wait back-pressure; dn_* ROM write handshake; mod, sw_flat,
// core_rst, dl_err outputs. Define DL_CHECKSUM_EN to add rom_sum.
module invaders_dl_ctrl
  import invaders_pkg::*;
#(
  parameter int RST_HOLD  = 16,
  parameter int ROM_BYTES = 8192
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  input  logic        dn_ready,
  output logic [7:0]  mod,
  output logic [63:0] sw_flat,
  output logic        core_rst,
  output logic        dl_err
`ifdef DL_CHECKSUM_EN
  ,
  output logic [7:0]  rom_sum
`endif
);

  localparam logic [7:0]  HOLD_N = 8'(RST_HOLD);
  localparam logic [16:0] ROM_N  = 17'(ROM_BYTES);

  dl_state_t   state;
  logic [16:0] byte_cnt;
  logic [7:0]  hold_cnt;
  logic        in_load;
  logic        wr_rom;
  logic        buf_ready;
  logic        push;
  logic        drop;
  logic        enter_load;

  assign in_load    = (state == LOAD);
  assign wr_rom     = in_load && ioctl_wr && (ioctl_index == IDX_ROM);
  assign push       = wr_rom && buf_ready;
  assign drop       = wr_rom && !buf_ready;
  assign ioctl_wait = dn_wr && !dn_ready;
  assign enter_load = ioctl_download &&
                      (state == IDLE || state == HOLD || state == RUN);

  invaders_dl_buf u_buf (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .in_valid  (push),
    .in_addr   (ioctl_addr[15:0]),
    .in_data   (ioctl_dout),
    .in_ready  (buf_ready),
    .out_valid (dn_wr),
    .out_addr  (dn_addr),
    .out_data  (dn_data),
    .out_ready (dn_ready)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      core_rst <= 1'b1;
      dl_err   <= 1'b0;
      mod      <= '0;
      sw_flat  <= '0;
      byte_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      if (drop)
        dl_err <= 1'b1;
      if (in_load && ioctl_wr) begin
        if (ioctl_index == IDX_MOD)
          mod <= ioctl_dout;
        if (ioctl_index == IDX_DIP && ioctl_addr[24:3] == '0)
          sw_flat[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        if (wr_rom)
          byte_cnt <= byte_cnt + 17'd1;
      end
      if (enter_load) begin
        state    <= LOAD;
        core_rst <= 1'b1;
        byte_cnt <= '0;
        hold_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: ;
          LOAD:
            if (!ioctl_download)
              state <= DRAIN;
          DRAIN:
            if (!dn_wr) begin
              state    <= HOLD;
              hold_cnt <= '0;
              if (byte_cnt != '0 && byte_cnt != ROM_N)
                dl_err <= 1'b1;
            end
          HOLD:
            if (hold_cnt + 8'd1 == HOLD_N) begin
              state    <= RUN;
              core_rst <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          RUN: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DL_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (reset)
      rom_sum <= '0;
    else if (enter_load)
      rom_sum <= '0;
    else if (dn_wr && dn_ready)
      rom_sum <= rom_sum + dn_data;
  end
`endif

endmodule

// File: tb/tb_invaders_dl_ctrl.sv
// Bench for invaders_dl_ctrl: directed and random ioctl traffic
// checked against a queue/array reference model.
module tb_invaders_dl_ctrl;

  localparam int RST_HOLD  = 16;
  localparam int ROM_BYTES = 8192;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_ready = 1'b0;
  logic [7:0]  mod;
  logic [63:0] sw_flat;
  logic        core_rst;
  logic        dl_err;
`ifdef DL_CHECKSUM_EN
  logic [7:0]  rom_sum;
`endif

  always #5 clk_sys = ~clk_sys;

  invaders_dl_ctrl #(
    .RST_HOLD  (RST_HOLD),
    .ROM_BYTES (ROM_BYTES)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .mod            (mod),
    .sw_flat        (sw_flat),
    .core_rst       (core_rst),
    .dl_err         (dl_err)
`ifdef DL_CHECKSUM_EN
    ,
    .rom_sum        (rom_sum)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_acc;
  int         n_bytes;
  bit         err_exp;
  bit         in_load;
  logic [7:0] sw_m[8];
  logic [7:0] mod_m;
  logic [7:0] sum_m;

  function automatic logic [63:0] sw_pack();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = sw_m[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check model vs DUT, cross the edge,
  // then fold the cycle's effects into the model.
  task automatic step(input logic rdy, input logic wr,
                      input logic [7:0] idx, input logic [24:0] a,
                      input logic [7:0] d);
    bit  full;
    bit  pop;
    wr_t e;
    logic [7:0] pd;
    dn_ready = rdy;
    ioctl_wr = wr;
    ioctl_index = idx;
    ioctl_addr = a;
    ioctl_dout = d;
    #1;
    full = (q.size() != 0);
    pop = full && rdy;
    pd = 8'h00;
    chk("dn_wr", dn_wr, full);
    chk("ioctl_wait", ioctl_wait, full && !rdy);
    chk("dl_err", dl_err, err_exp);
    chk("mod", mod, mod_m);
    chk("sw_flat", sw_flat, sw_pack());
`ifdef DL_CHECKSUM_EN
    chk("rom_sum", rom_sum, sum_m);
`endif
    if (full) begin
      chk("dn_addr", dn_addr, q[0].a);
      chk("dn_data", dn_data, q[0].d);
    end
    if (pop) begin
      pd = q[0].d;
      void'(q.pop_front());
    end
    @(posedge clk_sys);
    #1;
    ioctl_wr = 1'b0;
    if (pop) begin
      n_acc++;
      sum_m = sum_m + pd;
    end
    if (wr && in_load) begin
      if (idx == 8'd0) begin
        n_bytes++;
        if (full && !rdy) begin
          err_exp = 1'b1;
        end else begin
          e.a = a[15:0];
          e.d = d;
          q.push_back(e);
        end
      end else if (idx == 8'd1) begin
        mod_m = d;
      end else if (idx == 8'd254 && a < 25'd8) begin
        sw_m[a[2:0]] = d;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    dn_ready = 1'b0;
    q.delete();
    n_bytes = 0;
    n_acc = 0;
    err_exp = 1'b0;
    in_load = 1'b0;
    mod_m = '0;
    sum_m = '0;
    for (int i = 0; i < 8; i++) sw_m[i] = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_dn_wr", dn_wr, 1'b0);
    chk("rst_dl_err", dl_err, 1'b0);
    reset = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    step(1'b1, 1'b0, 8'd0, '0, '0);
    in_load = 1'b1;
    n_bytes = 0;
    sum_m = '0;
  endtask

  // Flush, leave LOAD, then time core_rst against the DRAIN exit.
  task automatic end_dl();
    step(1'b1, 1'b0, 8'd0, '0, '0);
    ioctl_download = 1'b0;
    step(1'b1, 1'b0, 8'd0, '0, '0);
    in_load = 1'b0;
    chk("drain_core_rst", core_rst, 1'b1);
    step(1'b1, 1'b0, 8'd0, '0, '0);
    if (n_bytes != 0 && n_bytes != ROM_BYTES) err_exp = 1'b1;
    for (int i = 1; i <= RST_HOLD; i++) begin
      step(1'b1, 1'b0, 8'd0, '0, '0);
      chk("hold_core_rst", core_rst, (i < RST_HOLD) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    logic [7:0]  idx_tab[6];
    logic [7:0]  ix;
    logic [24:0] ad;
    bit          rd;
    bit          w;

    do_reset();
    step(1'b1, 1'b0, 8'd0, '0, '0);
    chk("idle_core_rst", core_rst, 1'b1);
    chk("idle_mod", mod, 8'h00);
    chk("idle_sw", sw_flat, 64'h0);

    // Full-length ROM image, memory always ready.
    start_dl();
    n_acc = 0;
    for (int i = 0; i < ROM_BYTES; i++)
      step(1'b1, 1'b1, 8'd0, 25'(i), 8'($urandom));
    end_dl();
    chk("full_writes", n_acc, ROM_BYTES);
    chk("full_dl_err", dl_err, 1'b0);

    // Stall: byte 0x3C at 0x0010 held for 5 cycles.
    do_reset();
    start_dl();
    step(1'b1, 1'b1, 8'd0, 25'h10, 8'h3C);
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'd0, '0, '0);
      chk("stall_addr", dn_addr, 16'h0010);
    end
    step(1'b1, 1'b0, 8'd0, '0, '0);
    step(1'b1, 1'b0, 8'd0, '0, '0);
    chk("stall_single", n_acc, 1);

    // Overrun: second byte while full and not accepted.
    step(1'b1, 1'b1, 8'd0, 25'h20, 8'hAA);
    step(1'b0, 1'b1, 8'd0, 25'h21, 8'h55);
    step(1'b0, 1'b0, 8'd0, '0, '0);
    chk("overrun_err", dl_err, 1'b1);
    step(1'b1, 1'b0, 8'd0, '0, '0);

    // DIP and mod writes.
    step(1'b1, 1'b1, 8'd254, 25'd2, 8'hA5);
    step(1'b1, 1'b1, 8'd254, 25'd8, 8'hFF);
    step(1'b1, 1'b1, 8'd1, 25'd0, 8'h07);
    step(1'b1, 1'b1, 8'd77, 25'd3, 8'h99);
    step(1'b1, 1'b0, 8'd0, '0, '0);
    chk("dip_sw", sw_flat, 64'h0000_0000_00A5_0000);
    chk("dip_mod", mod, 8'h07);
    end_dl();
    chk("err_sticky", dl_err, 1'b1);

    // Random traffic, mostly honouring back-pressure.
    idx_tab[0] = 8'd0;
    idx_tab[1] = 8'd0;
    idx_tab[2] = 8'd0;
    idx_tab[3] = 8'd1;
    idx_tab[4] = 8'd254;
    idx_tab[5] = 8'd9;
    do_reset();
    start_dl();
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom_range(0, 2) != 0);
      w = ($urandom_range(0, 3) != 0);
      ix = idx_tab[$urandom_range(0, 5)];
      ad = (ix == 8'd254) ? 25'($urandom_range(0, 11)) : 25'($urandom);
      if (ix == 8'd0 && q.size() != 0 && !rd && $urandom_range(0, 7) != 0)
        w = 1'b0;
      step(rd, w, ix, ad, 8'($urandom));
    end
    end_dl();

    // Short image, then reset with a byte still held.
    do_reset();
    start_dl();
    for (int i = 0; i < 100; i++)
      step(1'b1, 1'b1, 8'd0, 25'(i), 8'(i));
    end_dl();
    chk("short_err", dl_err, 1'b1);
    start_dl();
    step(1'b0, 1'b1, 8'd0, 25'h40, 8'h5A);
    step(1'b0, 1'b0, 8'd0, '0, '0);
    reset = 1'b1;
    ioctl_download = 1'b0;
    q.delete();
    in_load = 1'b0;
    err_exp = 1'b0;
    mod_m = '0;
    sum_m = '0;
    for (int i = 0; i < 8; i++) sw_m[i] = '0;
    @(posedge clk_sys);
    #1;
    chk("rst_mid_dn_wr", dn_wr, 1'b0);
    chk("rst_mid_core_rst", core_rst, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'd0, '0, '0);
      chk("post_rst_core_rst", core_rst, 1'b1);
    end

`ifdef DL_CHECKSUM_EN
    do_reset();
    start_dl();
    step(1'b1, 1'b1, 8'd0, 25'd0, 8'hFF);
    step(1'b1, 1'b1, 8'd0, 25'd1, 8'h02);
    step(1'b1, 1'b1, 8'd0, 25'd2, 8'h10);
    step(1'b1, 1'b0, 8'd0, '0, '0);
    step(1'b1, 1'b0, 8'd0, '0, '0);
    chk("rom_sum", rom_sum, 8'h11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/invaders_dl_ctrl.md
INVADERS_DL_CTRL -- requirements
Module: invaders_dl_ctrl

Interface
REQ-001 The block SHALL have parameter RST_HOLD, default 16: clk_sys cycles core_rst stays high after a download ends (1..255).
REQ-002 The block SHALL have parameter ROM_BYTES, default 8192: expected ROM image length for ioctl_index 0.
REQ-003 clk_sys  in  1  system clock; every register is clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  HPS download in progress.
REQ-006 ioctl_wr  in  1  one-cycle byte strobe.
REQ-007 ioctl_addr  in  25  byte address.
REQ-008 ioctl_dout  in  8  byte data.
REQ-009 ioctl_index  in  8  target: 0 ROM, 1 mod select, 254 DIP.
REQ-010 ioctl_wait  out  1  back-pressure to HPS.
REQ-011 dn_addr  out  16  ROM write address.
REQ-012 dn_data  out  8  ROM write data.
REQ-013 dn_wr  out  1  ROM write request, held until accepted.
REQ-014 dn_ready  in  1  memory accepts dn_wr this cycle.
REQ-015 mod  out  8  game select byte.
REQ-016 sw_flat  out  64  DIP bytes sw[0..7]; sw[n] occupies bits 8n+7:8n.
REQ-017 core_rst  out  1  reset to CPU/video/audio.
REQ-018 dl_err  out  1  sticky: length mismatch or overrun.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DRAIN, HOLD, RUN.
REQ-020 IDLE -> LOAD on ioctl_download=1; LOAD -> DRAIN on ioctl_download=0; DRAIN -> HOLD when the holding buffer is empty; HOLD -> RUN when the hold counter reaches RST_HOLD; RUN -> LOAD on ioctl_download=1.
REQ-021 HOLD and RUN SHALL go to LOAD on ioctl_download=1, which restarts the sequence and resets the hold counter to 0.
REQ-022 core_rst SHALL be 1 in IDLE, LOAD, DRAIN and HOLD, and 0 only in RUN.
REQ-023 An index-0 byte SHALL load a one-entry holding buffer (addr = ioctl_addr[15:0], data) in the same cycle; dn_wr is asserted from the next cycle.
REQ-024 dn_wr, dn_addr and dn_data SHALL stay stable until a cycle with dn_wr=1 and dn_ready=1; the buffer empties in that cycle.
REQ-025 A new index-0 byte arriving in the same cycle as a buffer acceptance SHALL be captured without loss.
REQ-026 ioctl_wait SHALL equal the buffer-full state AND NOT dn_ready.
REQ-027 An index-0 byte arriving while the buffer is full and not accepted SHALL be dropped and SHALL set dl_err.
REQ-028 Index-1 bytes SHALL write mod directly; the last byte wins.
REQ-029 Index-254 bytes with ioctl_addr[24:3]=0 SHALL write sw[ioctl_addr[2:0]]; all other index-254 addresses are ignored.
REQ-030 Any other index value SHALL be ignored.
REQ-031 A 17-bit counter SHALL count index-0 bytes per download and clear on entry to LOAD.
REQ-032 On leaving DRAIN, dl_err SHALL be set if the byte count is nonzero and differs from ROM_BYTES.
REQ-033 Addresses at or above 65536 SHALL wrap through the [15:0] truncation and still be counted.
REQ-034 ioctl_wr outside LOAD SHALL be ignored.

Reset
REQ-035 Reset SHALL have priority over all other inputs and SHALL set state IDLE, buffer empty, dn_wr 0, ioctl_wait 0, core_rst 1, dl_err 0, mod 0, all sw bytes 0, and both counters 0.
REQ-036 Reset asserted mid-LOAD SHALL abandon the pending buffered byte, so no dn_wr is issued after reset.

Configuration
REQ-037 With DL_CHECKSUM_EN defined, the block SHALL add output rom_sum (8 bits): the modulo-256 sum of index-0 bytes accepted by memory, cleared on entry to LOAD and held after.
REQ-038 Without DL_CHECKSUM_EN, the block SHALL have no rom_sum port and no checksum logic.

Structure
REQ-039 A shared package invaders_pkg SHALL hold the FSM state enum and the constants IDX_ROM=0, IDX_MOD=1 and IDX_DIP=254.
REQ-040 Sub-module invaders_dl_buf SHALL implement the one-entry holding buffer with its valid/ready handshake; the FSM, counters and registers stay in the top block.

Verification
REQ-041 After reset, assert download and write 8192 index-0 bytes with dn_ready=1 -> 8192 dn_wr pulses with addresses 0..8191, dl_err=0, core_rst falling exactly RST_HOLD cycles after the DRAIN exit.
REQ-042 Hold dn_ready=0 for 5 cycles after byte 0x3C at 0x0010 -> dn_wr/addr/data stable for all 5 cycles, ioctl_wait=1, a single write on release.
REQ-043 Issue an index-0 byte while the buffer is full and dn_ready=0 -> byte not written, dl_err=1 and sticky until reset.
REQ-044 Write index 254 to addr 2 with 0xA5 and to addr 8 with 0xFF, then index 1 with 0x07 -> sw_flat[23:16]=0xA5, other sw bytes unchanged, mod=0x07.
REQ-045 Download 100 ROM bytes -> dl_err=1 after DRAIN; then reset mid-LOAD with the buffer full -> no further dn_wr and core_rst=1.
REQ-046 With DL_CHECKSUM_EN defined, load bytes 0xFF, 0x02 and 0x10 -> rom_sum=0x11.
